// File: rtl/pv2ooo_muldiv_wb_queue_if.sv
// Handshake bundle between issue / mul-div unit / writeback arbiter and the
// mul/div writeback queue.
interface pv2ooo_muldiv_wb_queue_if #(
    parameter int unsigned ROB_W = 4
);
    logic             tag_enq_val;
    logic             tag_enq_rdy;
    logic [4:0]       tag_enq_waddr;
    logic             tag_enq_sel_hi;
    logic [ROB_W-1:0] tag_enq_rob;

    logic [63:0]      muldivresp_msg_result;
    logic             muldivresp_val;
    logic             muldivresp_rdy;

    logic             wb_val;
    logic             wb_rdy;
    logic [4:0]       wb_waddr;
    logic [31:0]      wb_data;
    logic [ROB_W-1:0] wb_rob;

    modport master (
        output tag_enq_val, tag_enq_waddr, tag_enq_sel_hi, tag_enq_rob,
        output muldivresp_msg_result, muldivresp_val, wb_rdy,
        input  tag_enq_rdy, muldivresp_rdy, wb_val, wb_waddr, wb_data, wb_rob
    );

    modport slave (
        input  tag_enq_val, tag_enq_waddr, tag_enq_sel_hi, tag_enq_rob,
        input  muldivresp_msg_result, muldivresp_val, wb_rdy,
        output tag_enq_rdy, muldivresp_rdy, wb_val, wb_waddr, wb_data, wb_rob
    );
endinterface

// File: rtl/pv2ooo_muldiv_wb_queue.sv
// In-order tag FIFO pairing mul/div responses with destination metadata, feeding
// a one-entry writeback register. Optional macro: PV2OOO_MULDIV_WB_R0_DROP_EN.
module pv2ooo_muldiv_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ROB_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    pv2ooo_muldiv_wb_queue_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [4:0]       waddr;
        logic             sel_hi;
        logic [ROB_W-1:0] rob;
    } tag_t;

    tag_t             r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    logic             r_wb_val;
    logic [4:0]       r_wb_waddr;
    logic [31:0]      r_wb_data;
    logic [ROB_W-1:0] r_wb_rob;

    logic             w_enq_rdy;
    logic             w_resp_rdy;
    logic             w_out_free;
    logic             w_enq_fire;
    logic             w_resp_fire;
    logic             w_wb_fire;
    logic             w_load;
    tag_t             w_head;
    logic [31:0]      w_sel_data;

    always_comb begin
        w_out_free  = !r_wb_val || bus.wb_rdy;
        w_enq_rdy   = !reset && (r_count != FULL_CNT);
        w_resp_rdy  = !reset && (r_count != '0) && w_out_free;
        w_enq_fire  = bus.tag_enq_val && w_enq_rdy;
        w_resp_fire = bus.muldivresp_val && w_resp_rdy;
        w_wb_fire   = r_wb_val && bus.wb_rdy;
        w_head      = r_mem[r_rd_ptr];
        w_sel_data  = w_head.sel_hi ? bus.muldivresp_msg_result[63:32]
                                    : bus.muldivresp_msg_result[31:0];
`ifdef PV2OOO_MULDIV_WB_R0_DROP_EN
        w_load      = w_resp_fire && (w_head.waddr != '0);
`else
        w_load      = w_resp_fire;
`endif
    end

    assign bus.tag_enq_rdy    = w_enq_rdy;
    assign bus.muldivresp_rdy = w_resp_rdy;
    assign bus.wb_val         = r_wb_val;
    assign bus.wb_waddr       = r_wb_waddr;
    assign bus.wb_data        = r_wb_data;
    assign bus.wb_rob         = r_wb_rob;

    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_mem[r_wr_ptr] <= {bus.tag_enq_waddr, bus.tag_enq_sel_hi, bus.tag_enq_rob};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_resp_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_enq_fire && !w_resp_fire) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq_fire && w_resp_fire) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // A response only fires when the register is free, so a dropped r0 result
    // always leaves wb_val low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_val   <= 1'b0;
            r_wb_waddr <= '0;
            r_wb_data  <= '0;
            r_wb_rob   <= '0;
        end else if (w_load) begin
            r_wb_val   <= 1'b1;
            r_wb_waddr <= w_head.waddr;
            r_wb_data  <= w_sel_data;
            r_wb_rob   <= w_head.rob;
        end else if (w_resp_fire || w_wb_fire) begin
            r_wb_val   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pv2ooo_muldiv_wb_queue.sv
// Directed plus random checks of the mul/div writeback queue against a
// queue-based reference model.
module tb_pv2ooo_muldiv_wb_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ROB_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pv2ooo_muldiv_wb_queue_if #(.ROB_W(ROB_W)) bus ();

    pv2ooo_muldiv_wb_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]       waddr;
        logic             hi;
        logic [ROB_W-1:0] rob;
    } mtag_t;

    mtag_t            mq[$];
    logic [63:0]      rsp_q[$];
    bit               m_val;
    logic [4:0]       m_waddr;
    logic [31:0]      m_data;
    logic [ROB_W-1:0] m_rob;
    int               errors = 0;
    int               checks = 0;
    int               wb_cnt = 0;
    int               inflight = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit ev, input logic [4:0] wa, input bit hi,
                        input logic [ROB_W-1:0] rob, input bit rsp_en, input bit wr);
        bit e_enq_rdy, e_rsp_rdy, wb_fire, rsp_fire, enq_fire, drop;
        mtag_t t;
        logic [63:0] r;
        @(negedge clk);
        bus.tag_enq_val           = ev;
        bus.tag_enq_waddr         = wa;
        bus.tag_enq_sel_hi        = hi;
        bus.tag_enq_rob           = rob;
        bus.muldivresp_val        = rsp_en && (rsp_q.size() > 0);
        bus.muldivresp_msg_result = (rsp_q.size() > 0) ? rsp_q[0] : 64'h0;
        bus.wb_rdy                = wr;
        #1;
        e_enq_rdy = mq.size() < DEPTH;
        e_rsp_rdy = (mq.size() != 0) && (!m_val || wr);
        chk("tag_enq_rdy", bus.tag_enq_rdy, e_enq_rdy);
        chk("muldivresp_rdy", bus.muldivresp_rdy, e_rsp_rdy);
        chk("wb_val", bus.wb_val, m_val);
        if (m_val) begin
            chk("wb_waddr", bus.wb_waddr, m_waddr);
            chk("wb_data", bus.wb_data, m_data);
            chk("wb_rob", bus.wb_rob, m_rob);
        end
        wb_fire  = m_val && wr;
        rsp_fire = bus.muldivresp_val && e_rsp_rdy;
        enq_fire = ev && e_enq_rdy;
        if (wb_fire) begin
            wb_cnt++;
            m_val = 1'b0;
        end
        if (rsp_fire) begin
            t = mq.pop_front();
            r = rsp_q.pop_front();
            inflight--;
`ifdef PV2OOO_MULDIV_WB_R0_DROP_EN
            drop = (t.waddr == 5'd0);
`else
            drop = 1'b0;
`endif
            m_val = !drop;
            if (!drop) begin
                m_waddr = t.waddr;
                m_rob   = t.rob;
                m_data  = t.hi ? r[63:32] : r[31:0];
            end
        end
        if (enq_fire) begin
            mq.push_back('{waddr: wa, hi: hi, rob: rob});
            inflight++;
        end
    endtask

    task automatic idle(input bit wr);
        step(1'b0, 5'd0, 1'b0, '0, 1'b0, wr);
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(1'b0, 5'd0, 1'b0, '0, 1'b1, 1'b1);
            done = (mq.size() == 0) && (rsp_q.size() == 0) && !m_val;
        end
        chk(tag, done, 1'b1);
    endtask

    initial begin
        int wb0;
        reset                     = 1'b1;
        bus.tag_enq_val           = 1'b0;
        bus.tag_enq_waddr         = '0;
        bus.tag_enq_sel_hi        = 1'b0;
        bus.tag_enq_rob           = '0;
        bus.muldivresp_val        = 1'b0;
        bus.muldivresp_msg_result = '0;
        bus.wb_rdy                = 1'b0;
        m_val = 1'b0; m_waddr = '0; m_data = '0; m_rob = '0;
        #1;
        chk("rst_wb_val", bus.wb_val, 1'b0);
        chk("rst_wb_waddr", bus.wb_waddr, 5'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_rob", bus.wb_rob, '0);
        chk("rst_enq_rdy", bus.tag_enq_rdy, 1'b0);
        chk("rst_resp_rdy", bus.muldivresp_rdy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // mul: low half selected
        step(1'b1, 5'd5, 1'b0, 4'd2, 1'b0, 1'b1);
        rsp_q.push_back(64'h00000000_00000018);
        step(1'b0, 5'd0, 1'b0, '0, 1'b1, 1'b1);
        idle(1'b1);
        chk("lo_data", bus.wb_data, 32'h18);
        chk("lo_waddr", bus.wb_waddr, 5'd5);
        idle(1'b1);
        chk("lo_held_one", bus.wb_val, 1'b0);

        // rem: high half, then same result with low select
        step(1'b1, 5'd7, 1'b1, 4'd3, 1'b0, 1'b1);
        step(1'b1, 5'd7, 1'b0, 4'd4, 1'b0, 1'b1);
        rsp_q.push_back(64'h0000002e_0000000a);
        rsp_q.push_back(64'h0000002e_0000000a);
        step(1'b0, 5'd0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 5'd0, 1'b0, '0, 1'b1, 1'b1);
        chk("hi_data", bus.wb_data, 32'h2e);
        idle(1'b1);
        chk("lo2_data", bus.wb_data, 32'h0a);
        drain("drain_sel");

        // full boundary
        for (int i = 0; i < 4; i++) step(1'b1, 5'(i + 8), 1'b0, 4'(i), 1'b0, 1'b1);
        step(1'b1, 5'd20, 1'b0, 4'd9, 1'b0, 1'b1);
        chk("full_rdy", bus.tag_enq_rdy, 1'b0);
        for (int i = 0; i < 4; i++) rsp_q.push_back(64'(i) * 64'h1_0000_0101);
        drain("drain_full");

        // empty boundary, then enqueue and response in the same cycle
        rsp_q.push_back(64'h12345678_9abcdef0);
        step(1'b0, 5'd0, 1'b0, '0, 1'b1, 1'b1);
        chk("empty_resp_rdy", bus.muldivresp_rdy, 1'b0);
        step(1'b1, 5'd9, 1'b0, 4'd5, 1'b1, 1'b1);
        chk("same_cyc_rdy", bus.muldivresp_rdy, 1'b0);
        step(1'b0, 5'd0, 1'b0, '0, 1'b1, 1'b1);
        chk("next_cyc_rdy", bus.muldivresp_rdy, 1'b1);
        drain("drain_empty");

        // backpressure and ordering
        for (int i = 1; i <= 3; i++) step(1'b1, 5'(i), 1'b0, 4'(i), 1'b0, 1'b0);
        rsp_q.push_back(64'h11);
        rsp_q.push_back(64'h22);
        rsp_q.push_back(64'h33);
        step(1'b0, 5'd0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 1'b0, '0, 1'b1, 1'b0);
            chk("bp_hold", bus.wb_data, 32'h11);
            chk("bp_resp_rdy", bus.muldivresp_rdy, 1'b0);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 5'd0, 1'b0, '0, 1'b1, 1'b1);
            chk("order_waddr", bus.wb_waddr, 5'(i));
            chk("order_data", bus.wb_data, 32'(i) * 32'h11);
        end
        drain("drain_bp");

        // asynchronous reset with tags pending and a writeback held
        for (int i = 0; i < 3; i++) step(1'b1, 5'(i + 12), 1'b1, 4'(i), 1'b0, 1'b0);
        rsp_q.push_back(64'hdead_beef_0000_0001);
        step(1'b0, 5'd0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 1'b0, '0, 1'b0, 1'b0);
        chk("pre_rst_wb_val", bus.wb_val, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_wb_val", bus.wb_val, 1'b0);
        chk("async_enq_rdy", bus.tag_enq_rdy, 1'b0);
        chk("async_resp_rdy", bus.muldivresp_rdy, 1'b0);
        mq.delete();
        rsp_q.delete();
        m_val = 1'b0;
        inflight = 0;
        @(negedge clk);
        reset = 1'b0;
        idle(1'b1);
        chk("post_rst_enq_rdy", bus.tag_enq_rdy, 1'b1);
        chk("post_rst_resp_rdy", bus.muldivresp_rdy, 1'b0);

        // writes to r0
        wb0 = wb_cnt;
        step(1'b1, 5'd0, 1'b0, 4'd1, 1'b0, 1'b1);
        step(1'b1, 5'd4, 1'b0, 4'd2, 1'b0, 1'b1);
        rsp_q.push_back(64'h5);
        rsp_q.push_back(64'h6);
        drain("drain_r0");
`ifdef PV2OOO_MULDIV_WB_R0_DROP_EN
        chk("r0_wb_count", wb_cnt - wb0, 1);
`else
        chk("r0_wb_count", wb_cnt - wb0, 2);
`endif

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if (rsp_q.size() < inflight && $urandom_range(1, 0) == 1) begin
                rsp_q.push_back({$urandom(), $urandom()});
            end
            step(1'($urandom_range(1, 0)), 5'($urandom()), 1'($urandom_range(1, 0)),
                 ROB_W'($urandom()), $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
        end
        while (rsp_q.size() < inflight) rsp_q.push_back({$urandom(), $urandom()});
        drain("drain_rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
